// File: rtl/mem_io_bridge_pkg.sv
// mem_io_bridge_pkg: I/O map constants, read-select type and byte helper for mem_io_bridge
package mem_io_bridge_pkg;
   localparam logic [17:0] IO_BASE       = 18'h30000;
   localparam logic [17:0] IO_UART_ADDR  = IO_BASE;
   localparam logic [17:0] IO_CLK_ADDR   = IO_BASE + 18'h4;
   localparam logic [17:0] IO_STALL_ADDR = IO_BASE + 18'h8;
   localparam logic [1:0]  IO_SEL_BIT    = 2'b11;
   typedef enum logic {SEL_RAM, SEL_IO} rd_sel_t;
   function automatic logic [7:0] byte_of(input logic [31:0] v, input logic [1:0] i);
      return v[{i, 3'b000} +: 8];
   endfunction
endpackage

// File: rtl/mem_io_bridge_fifo.sv
// io_tx_fifo: UART TX byte FIFO with registered near-full flag and sticky overflow flag
// Ports: clk_in, rst_in (sync, active-low); push/push_data enqueue; ready dequeues the head
//   when valid; data/valid present the head; full, near_full, count, overflow report status.
module io_tx_fifo
   import mem_io_bridge_pkg::*;
#(
   parameter int TX_DEPTH_BIT = 4,
   parameter int FULL_MARGIN  = 2
) (
   input  logic                  clk_in,
   input  logic                  rst_in,
   input  logic                  push,
   input  logic [7:0]            push_data,
   input  logic                  ready,
   output logic [7:0]            data,
   output logic                  valid,
   output logic                  full,
   output logic                  near_full,
   output logic [TX_DEPTH_BIT:0] count,
   output logic                  overflow
);
   localparam int DEPTH = 1 << TX_DEPTH_BIT;
   localparam logic [TX_DEPTH_BIT:0] NEAR_LEVEL = (TX_DEPTH_BIT + 1)'(DEPTH - FULL_MARGIN);
   logic [7:0] mem [DEPTH];
   logic [TX_DEPTH_BIT-1:0] wr_ptr, rd_ptr;
   logic [TX_DEPTH_BIT:0] count_next;
   logic do_push, do_pop;
   assign valid = count != '0;
   assign full = count == (TX_DEPTH_BIT + 1)'(DEPTH);
   assign data = mem[rd_ptr];
   assign do_pop = valid && ready;
   // a same-cycle pop frees the slot a push into a full FIFO needs
   assign do_push = push && (!full || do_pop);
   assign count_next = count + (TX_DEPTH_BIT + 1)'(do_push) - (TX_DEPTH_BIT + 1)'(do_pop);
   always_ff @(posedge clk_in) begin
      if (!rst_in) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count <= '0;
         near_full <= 1'b0;
         overflow <= 1'b0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + TX_DEPTH_BIT'(1);
         if (do_pop) rd_ptr <= rd_ptr + TX_DEPTH_BIT'(1);
         count <= count_next;
         near_full <= count_next >= NEAR_LEVEL;
         overflow <= overflow || (push && !do_push);
      end
   end
   always_ff @(posedge clk_in) begin
      if (do_push) mem[wr_ptr] <= push_data;
   end
endmodule

// File: rtl/mem_io_bridge.sv
// mem_io_bridge: routes CPU byte accesses to RAM or the memory-mapped I/O window
// Ports: clk_in, rst_in (sync, active-low); cpu_a/cpu_wr/cpu_dout/cpu_din CPU bus;
//   io_buffer_full back-pressure; ram_a/ram_we/ram_dout/ram_din RAM port;
//   tx_data/tx_valid/tx_ready UART TX; rx_data/rx_valid/rx_pop UART RX;
//   program_stop sticky stop flag; stop_done stop flag with TX drained.
// Optional: define BRIDGE_STALL_COUNT_EN to add a stall-cycle counter at 0x30008..0x3000B.
module mem_io_bridge
   import mem_io_bridge_pkg::*;
#(
   parameter int TX_DEPTH_BIT = 4,
   parameter int FULL_MARGIN  = 2,
   parameter int RAM_ADDR_BIT = 17
) (
   input  logic                    clk_in,
   input  logic                    rst_in,
   input  logic [31:0]             cpu_a,
   input  logic                    cpu_wr,
   input  logic [7:0]              cpu_dout,
   output logic [7:0]              cpu_din,
   output logic                    io_buffer_full,
   output logic [RAM_ADDR_BIT-1:0] ram_a,
   output logic                    ram_we,
   output logic [7:0]              ram_dout,
   input  logic [7:0]              ram_din,
   output logic [7:0]              tx_data,
   output logic                    tx_valid,
   input  logic                    tx_ready,
   input  logic [7:0]              rx_data,
   input  logic                    rx_valid,
   output logic                    rx_pop,
   output logic                    program_stop,
   output logic                    stop_done
);
   logic is_io, wr_io, rd_io, rd_uart, rd_clk, wr_stop, tx_push, primed, tx_full, overflow;
   logic [7:0] tx_push_data, io_next, io_rdata;
   logic [31:0] cycles, cycles_snap;
   logic [TX_DEPTH_BIT:0] tx_count;
   rd_sel_t sel;
   assign is_io = cpu_a[17:16] == IO_SEL_BIT;
   assign ram_a = cpu_a[RAM_ADDR_BIT-1:0];
   assign ram_dout = cpu_dout;
   assign ram_we = rst_in && cpu_wr && !is_io;
   assign wr_io = cpu_wr && is_io;
   assign rd_io = !cpu_wr && is_io;
   assign wr_stop = wr_io && cpu_a[17:0] == IO_CLK_ADDR;
   // the stop write queues a 0x00 marker that bypasses the zero filter
   assign tx_push = wr_stop || (wr_io && cpu_a[17:0] == IO_UART_ADDR && cpu_dout != 8'h00);
   assign tx_push_data = wr_stop ? 8'h00 : cpu_dout;
   assign rd_uart = rd_io && cpu_a[17:0] == IO_UART_ADDR;
   assign rd_clk = rd_io && cpu_a[17:2] == IO_CLK_ADDR[17:2];
`ifdef BRIDGE_STALL_COUNT_EN
   logic rd_stall;
   logic [31:0] stalls, stalls_snap;
   assign rd_stall = rd_io && cpu_a[17:2] == IO_STALL_ADDR[17:2];
   always_ff @(posedge clk_in) begin
      if (!rst_in) begin
         stalls <= '0;
         stalls_snap <= '0;
      end else begin
         if (io_buffer_full) stalls <= stalls + 32'd1;
         if (rd_stall && cpu_a[1:0] == 2'd0) stalls_snap <= stalls;
      end
   end
`endif
   // byte 0 reads the live counter; the upper bytes come from the snapshot it takes
   always_comb begin
      io_next = 8'h00;
      if (rd_uart) io_next = rx_valid ? rx_data : 8'h00;
      if (rd_clk) io_next = cpu_a[1:0] == 2'd0 ? cycles[7:0] : byte_of(cycles_snap, cpu_a[1:0]);
`ifdef BRIDGE_STALL_COUNT_EN
      if (rd_stall) io_next = cpu_a[1:0] == 2'd0 ? stalls[7:0] : byte_of(stalls_snap, cpu_a[1:0]);
`endif
   end
   always_ff @(posedge clk_in) begin
      if (!rst_in) begin
         sel <= SEL_RAM;
         primed <= 1'b0;
         io_rdata <= 8'h00;
         rx_pop <= 1'b0;
         cycles <= '0;
         cycles_snap <= '0;
         program_stop <= 1'b0;
         stop_done <= 1'b0;
      end else begin
         sel <= is_io ? SEL_IO : SEL_RAM;
         primed <= 1'b1;
         io_rdata <= io_next;
         rx_pop <= rd_uart && rx_valid;
         cycles <= cycles + 32'd1;
         if (rd_clk && cpu_a[1:0] == 2'd0) cycles_snap <= cycles;
         if (wr_stop) program_stop <= 1'b1;
         stop_done <= program_stop && tx_count == '0;
      end
   end
   // primed masks a read that was in flight across reset
   assign cpu_din = !primed ? 8'h00 : sel == SEL_RAM ? ram_din : io_rdata;
   io_tx_fifo #(
      .TX_DEPTH_BIT(TX_DEPTH_BIT),
      .FULL_MARGIN (FULL_MARGIN)
   ) u_fifo (
      .clk_in   (clk_in),
      .rst_in   (rst_in),
      .push     (tx_push),
      .push_data(tx_push_data),
      .ready    (tx_ready),
      .data     (tx_data),
      .valid    (tx_valid),
      .full     (tx_full),
      .near_full(io_buffer_full),
      .count    (tx_count),
      .overflow (overflow)
   );
   logic unused;
   assign unused = ^{cpu_a[31:18], tx_full, overflow};
endmodule

// File: tb/tb_mem_io_bridge.sv
// tb_mem_io_bridge: directed scoreboard bench for mem_io_bridge
module tb_mem_io_bridge;
   logic clk_in = 1'b0, rst_in = 1'b0;
   logic [31:0] cpu_a = '0;
   logic cpu_wr = 1'b0;
   logic [7:0] cpu_dout = '0, cpu_din;
   logic io_buffer_full;
   logic [16:0] ram_a;
   logic ram_we;
   logic [7:0] ram_dout, ram_din = '0;
   logic [7:0] tx_data;
   logic tx_valid, tx_ready = 1'b0;
   logic [7:0] rx_data = '0;
   logic rx_valid = 1'b0, rx_pop, program_stop, stop_done;
   always #5 clk_in = ~clk_in;
   mem_io_bridge dut (
      .clk_in(clk_in), .rst_in(rst_in), .cpu_a(cpu_a), .cpu_wr(cpu_wr), .cpu_dout(cpu_dout),
      .cpu_din(cpu_din), .io_buffer_full(io_buffer_full), .ram_a(ram_a), .ram_we(ram_we),
      .ram_dout(ram_dout), .ram_din(ram_din), .tx_data(tx_data), .tx_valid(tx_valid),
      .tx_ready(tx_ready), .rx_data(rx_data), .rx_valid(rx_valid), .rx_pop(rx_pop),
      .program_stop(program_stop), .stop_done(stop_done)
   );
   logic [7:0] ram [1 << 17];
   logic [7:0] tx_q [$];
   logic [7:0] rd_q [$];
   logic [31:0] cyc = '0, snap;
   logic [7:0] b0, b1, b2, b3;
   int vectors = 0, miscompares = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // one clock: score any TX pop, advance the RAM and cycle-counter models
   task automatic tick();
      logic [7:0] nxt;
      @(negedge clk_in);
      if (tx_valid && tx_ready) begin
         chk("tx_pop_expected", 32'(tx_q.size() != 0), 32'd1);
         if (tx_q.size() != 0) chk("tx_data", tx_data, tx_q.pop_front());
      end
      @(posedge clk_in);
      #1;
      nxt = ram[ram_a];
      if (ram_we) ram[ram_a] = ram_dout;
      ram_din = nxt;
      cyc = rst_in ? cyc + 32'd1 : 32'd0;
      #1;
   endtask

   task automatic idle();
      cpu_a = '0;
      cpu_wr = 1'b0;
   endtask

   task automatic wr(input logic [31:0] a, input logic [7:0] d);
      cpu_a = a;
      cpu_wr = 1'b1;
      cpu_dout = d;
      tick();
      idle();
   endtask

   task automatic rd(input string tag, input logic [31:0] a, input logic [7:0] exp, output logic [7:0] got);
      cpu_a = a;
      cpu_wr = 1'b0;
      rd_q.push_back(exp);
      tick();
      got = cpu_din;
      chk(tag, cpu_din, rd_q.pop_front());
      idle();
   endtask

   task automatic drain(input string tag);
      tx_ready = 1'b1;
      for (int i = 0; i < 64 && tx_q.size() != 0; i++) tick();
      chk(tag, tx_q.size(), 0);
      repeat (3) tick();
      chk({tag, "_empty"}, tx_valid, 1'b0);
   endtask

   initial begin
      cpu_a = 32'h10;
      cpu_wr = 1'b1;
      cpu_dout = 8'hEE;
      repeat (2) tick();
      chk("rst_ram_we", ram_we, 1'b0);
      chk("rst_cpu_din", cpu_din, 8'h00);
      chk("rst_tx_valid", tx_valid, 1'b0);
      chk("rst_full", io_buffer_full, 1'b0);
      chk("rst_stop", program_stop, 1'b0);
      chk("rst_done", stop_done, 1'b0);
      chk("rst_rx_pop", rx_pop, 1'b0);
      idle();
      rst_in = 1'b1;
      while (cyc != 32'h1234) tick();
      snap = cyc;
      rd("clk_b0", 32'h30004, snap[7:0], b0);
      rd("clk_b1", 32'h30005, snap[15:8], b1);
      rd("clk_b2", 32'h30006, snap[23:16], b2);
      rd("clk_b3", 32'h30007, snap[31:24], b3);
      chk("clk_value", {b3, b2, b1, b0}, 32'h1234);
      repeat (300) tick();
      rd("clk_snap_hold", 32'h30005, snap[15:8], b1);
      cpu_a = 32'h10;
      cpu_wr = 1'b1;
      cpu_dout = 8'hA5;
      #1;
      chk("ram_we_on", ram_we, 1'b1);
      chk("ram_a", ram_a, 17'h10);
      chk("ram_dout", ram_dout, 8'hA5);
      tick();
      idle();
      #1;
      chk("ram_we_pulse", ram_we, 1'b0);
      rd("ram_rd", 32'h10, 8'hA5, b0);
      cpu_a = 32'h10020;
      cpu_wr = 1'b1;
      cpu_dout = 8'h5C;
      #1;
      chk("ram_we_hi", ram_we, 1'b1);
      chk("ram_a_hi", ram_a, 17'h10020);
      tick();
      cpu_a = 32'h30010;
      cpu_dout = 8'h77;
      #1;
      chk("io_no_ram_we", ram_we, 1'b0);
      tick();
      idle();
      rd("ram_rd_hi", 32'h10020, 8'h5C, b0);
      rd("io_other", 32'h30010, 8'h00, b0);
      rx_data = 8'h5A;
      rx_valid = 1'b1;
      rd("rx_rd", 32'h30000, 8'h5A, b0);
      chk("rx_pop_on", rx_pop, 1'b1);
      rx_valid = 1'b0;
      tick();
      chk("rx_pop_off", rx_pop, 1'b0);
      rd("rx_none", 32'h30000, 8'h00, b0);
      chk("rx_pop_none", rx_pop, 1'b0);
      tx_q.push_back(8'h48);
      wr(32'h30000, 8'h48);
      wr(32'h30000, 8'h00);
      tx_q.push_back(8'h69);
      wr(32'h30000, 8'h69);
      drain("uart_drain");
      tx_ready = 1'b0;
      for (int i = 0; i < 14; i++) begin
         tx_q.push_back(8'h41);
         wr(32'h30000, 8'h41);
         if (i == 12) chk("nf_13", io_buffer_full, 1'b0);
      end
      chk("nf_14", io_buffer_full, 1'b1);
      tx_q.push_back(8'h42);
      wr(32'h30000, 8'h42);
      tx_q.push_back(8'h43);
      wr(32'h30000, 8'h43);
      wr(32'h30000, 8'h44);
      chk("nf_full", io_buffer_full, 1'b1);
      drain("full_drain");
      chk("nf_clear", io_buffer_full, 1'b0);
      tx_ready = 1'b1;
      tx_q.push_back(8'h31);
      wr(32'h30000, 8'h31);
      tx_q.push_back(8'h32);
      wr(32'h30000, 8'h32);
      chk("stop_before", program_stop, 1'b0);
      tx_q.push_back(8'h00);
      wr(32'h30004, 8'h55);
      chk("stop_rise", program_stop, 1'b1);
      chk("stop_done_early", stop_done, 1'b0);
      drain("stop_drain");
      chk("stop_done", stop_done, 1'b1);
      chk("stop_sticky", program_stop, 1'b1);
      tx_ready = 1'b0;
      for (int i = 0; i < 5; i++) wr(32'h30000, 8'h61 + 8'(i));
      chk("pre_rst_valid", tx_valid, 1'b1);
      tx_q.delete();
      rst_in = 1'b0;
      cpu_a = 32'h10;
      cpu_wr = 1'b0;
      tick();
      chk("mid_rst_valid", tx_valid, 1'b0);
      chk("mid_rst_full", io_buffer_full, 1'b0);
      chk("mid_rst_stop", program_stop, 1'b0);
      chk("mid_rst_done", stop_done, 1'b0);
      chk("mid_rst_din", cpu_din, 8'h00);
      rst_in = 1'b1;
      rd("mid_rst_cnt", 32'h30004, cyc[7:0], b0);
      tx_ready = 1'b1;
      repeat (3) tick();
      chk("mid_rst_discard", tx_valid, 1'b0);
      rd("stall_rd", 32'h30008, 8'h00, b0);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
